clk_divider_multi: RTL
======================

Name: clk_divider_multi

Overview:
Parametrised multi-channel clock/tick divider for the digital clock and display timing. NUM_CH independent channels divide i_clk by a runtime-programmable integer. Each channel produces a square wave and a one-cycle tick. The block replaces the fixed single-rate dividers: display scan, seconds base, blink and debounce sampling all come from one instance, with glitch-free rate changes and a common phase-align input.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 28, width of the counter and divisor registers
CH_W, 2, width of the channel select; must satisfy 2^CH_W >= NUM_CH
DEFAULT_DIV, 250000, reset divisor for every channel (400 Hz from 100 MHz); must be >= 2

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst  in  1  reset; synchronous and active-high
i_en  in  NUM_CH  per-channel run enable
i_sync  in  1  single-cycle pulse; phase-aligns all channels
i_wr_en  in  1  divisor write strobe
i_wr_ch  in  CH_W  target channel of the write
i_wr_div  in  CNT_W  new divisor, i.e. the period in i_clk cycles
o_wr_err  out  1  one-cycle pulse on a rejected write
o_pending  out  NUM_CH  channel holds a divisor not yet applied
o_clk  out  NUM_CH  divided square wave per channel
o_tick  out  NUM_CH  one-cycle pulse per period per channel

Behaviour:
- Only one clock. Reset is synchronous and active-high on i_rst. All state updates on posedge i_clk.
- Priority: i_rst > i_sync > normal counting.
- Reset values:
  - cnt = 0, div_act = DEFAULT_DIV, shadow = DEFAULT_DIV, pending = 0.
  - o_clk = 0, o_tick = 0, o_wr_err = 0, o_pending = 0.
- Counting (channel enabled, no sync):
  - cnt <= (cnt == div_act-1) ? 0 : cnt+1.
  - The period is exactly div_act cycles. There is no extra count.
- Outputs are registered from the pre-update cnt:
  - o_clk <= (cnt >= div_act>>1).
  - o_tick <= (cnt == div_act-1).
  - Result: low for floor(div/2) cycles, then high for ceil(div/2) cycles. o_tick is high in the cycle in which cnt reads 0.
- Divisor write (i_wr_en = 1):
  - Rejected if i_wr_div < 2 or i_wr_ch >= NUM_CH. A rejected write sets o_wr_err = 1 in the next cycle and changes no state.
  - Otherwise shadow[ch] <= i_wr_div and pending[ch] <= 1.
  - A write while already pending overwrites shadow. The last write wins.
- Apply point:
  - At the period boundary (enabled and cnt == div_act-1): if pending, div_act <= shadow and pending <= 0.
  - A valid write in the boundary cycle bypasses the shadow: its value becomes div_act at that boundary.
  - A rate change never truncates or stretches a period in progress.
- Disabled channel (i_en[ch] = 0):
  - cnt held at 0; o_clk and o_tick forced to 0 next cycle.
  - A pending shadow is applied immediately, so div_act <= shadow and pending clears.
  - When i_en rises, counting starts from cnt = 0. The first o_tick arrives div_act cycles after the first enabled cycle.
- i_sync:
  - All enabled channels: cnt <= 0, and pending divisors apply immediately.
  - o_clk and o_tick go to 0 next cycle, with no tick for the truncated period.
  - A valid write in the same cycle as i_sync applies immediately.
- o_pending mirrors the pending register.
- Reset mid-period: all channels return to reset values. A write in the reset cycle is discarded.
- Counter wrap: cnt never exceeds div_act-1. CNT_W is sized by the user; there is no overflow detection beyond that.

Test Plan:
- Reset with default divisor: NUM_CH=4, DEFAULT_DIV=250000, i_en=4'hF.
  - Required: o_tick on each channel every 250000 cycles.
  - Required: o_clk low for 125000 cycles, then high for 125000 cycles.
- Small odd and even divisors: write ch1 div=5 while ch1 is disabled, then enable.
  - Required: o_tick every 5 cycles; o_clk pattern 0,0,1,1,1 repeating.
  - Write ch2 div=4. Required: o_clk pattern 0,0,1,1.
- Glitch-free change: ch0 running div=10, write div=4 at cnt=3.
  - Required: o_pending[0] = 1 until the boundary at cnt = 9.
  - Required: the current period completes at 10 cycles, and the next period is 4 cycles.
  - Also write at cnt=9 (boundary bypass). Required: the next period is 4 cycles.
- Rejected writes: i_wr_div=1, i_wr_div=0, and i_wr_ch=3 with NUM_CH=3.
  - Required: o_wr_err pulses one cycle after each write; no change in any channel's period.
- Phase align: ch0 div=6 and ch1 div=6 running at different phases, then pulse i_sync.
  - Required: from then on, o_tick[0] and o_tick[1] coincide every 6 cycles.
  - Required: no tick is emitted for the truncated period.
- Mid-operation reset and enable edge: assert i_rst at an arbitrary cnt with a write pending.
  - Required: all outputs are 0 next cycle, o_pending = 0, and periods revert to DEFAULT_DIV.
  - Deassert i_en for 3 cycles. Required: o_clk = 0 during that time, and the first tick comes div cycles after re-enable.

Source files
------------

// File: rtl/clk_divider_multi.sv
// clk_divider_multi
// Multi-channel integer divider of i_clk. Each channel emits a square wave
// (low for floor(div/2) cycles, then high for ceil(div/2) cycles) and a
// one-cycle tick per period. Divisors are written into a per-channel shadow
// register and are taken over only at a period boundary, when the channel is
// disabled, or on i_sync, so a rate change never produces a runt period.
module clk_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int CH_W        = 2,
  parameter int DEFAULT_DIV = 250000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_sync,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [CNT_W-1:0]  i_wr_div,
  output logic              o_wr_err,
  output logic [NUM_CH-1:0] o_pending,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W+1)'(NUM_CH);

  // Per-channel state, current and next.
  logic [CNT_W-1:0]  cnt_r     [NUM_CH];
  logic [CNT_W-1:0]  cnt_s     [NUM_CH];
  logic [CNT_W-1:0]  div_act_r [NUM_CH];
  logic [CNT_W-1:0]  div_act_s [NUM_CH];
  logic [CNT_W-1:0]  shadow_r  [NUM_CH];
  logic [CNT_W-1:0]  shadow_s  [NUM_CH];
  logic [NUM_CH-1:0] pending_r;
  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] clk_r;
  logic [NUM_CH-1:0] clk_s;
  logic [NUM_CH-1:0] tick_r;
  logic [NUM_CH-1:0] tick_s;
  logic              wr_err_r;
  logic              wr_err_s;

  // Decoded write and boundary qualifiers.
  logic              wr_ok_s;
  logic [NUM_CH-1:0] wr_hit_s;
  logic [NUM_CH-1:0] last_s;

  // Next-state logic: write decode, counting, divisor hand-over and outputs.
  always_comb begin
    wr_ok_s  = i_wr_en && (i_wr_div >= DIV_MIN) && ({1'b0, i_wr_ch} < CH_LIMIT);
    wr_err_s = i_wr_en && !wr_ok_s;
    wr_hit_s = '0;
    last_s   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      cnt_s[ch]     = cnt_r[ch];
      div_act_s[ch] = div_act_r[ch];
      shadow_s[ch]  = shadow_r[ch];
      pending_s[ch] = pending_r[ch];
      clk_s[ch]     = 1'b0;
      tick_s[ch]    = 1'b0;
      wr_hit_s[ch]  = wr_ok_s && (i_wr_ch == CH_W'(ch));
      last_s[ch]    = (cnt_r[ch] == (div_act_r[ch] - CNT_ONE));

      if (!i_en[ch] || i_sync) begin
        // Held or realigned: restart at zero and adopt any new divisor now,
        // a same-cycle write taking precedence over an older shadow value.
        cnt_s[ch] = '0;
        if (wr_hit_s[ch]) begin
          div_act_s[ch] = i_wr_div;
          shadow_s[ch]  = i_wr_div;
          pending_s[ch] = 1'b0;
        end else if (pending_r[ch]) begin
          div_act_s[ch] = shadow_r[ch];
          pending_s[ch] = 1'b0;
        end else begin
          div_act_s[ch] = div_act_r[ch];
        end
      end else begin
        // Outputs follow the count value seen in this cycle.
        clk_s[ch]  = (cnt_r[ch] >= {1'b0, div_act_r[ch][CNT_W-1:1]});
        tick_s[ch] = last_s[ch];
        if (last_s[ch]) begin
          // Period boundary: the only point a running channel changes rate.
          cnt_s[ch] = '0;
          if (wr_hit_s[ch]) begin
            div_act_s[ch] = i_wr_div;
            shadow_s[ch]  = i_wr_div;
            pending_s[ch] = 1'b0;
          end else if (pending_r[ch]) begin
            div_act_s[ch] = shadow_r[ch];
            pending_s[ch] = 1'b0;
          end else begin
            div_act_s[ch] = div_act_r[ch];
          end
        end else begin
          cnt_s[ch] = cnt_r[ch] + CNT_ONE;
          if (wr_hit_s[ch]) begin
            // Park the new divisor; a later write before the boundary wins.
            shadow_s[ch]  = i_wr_div;
            pending_s[ch] = 1'b1;
          end else begin
            shadow_s[ch]  = shadow_r[ch];
          end
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_r[ch]     <= '0;
        div_act_r[ch] <= DIV_RST;
        shadow_r[ch]  <= DIV_RST;
      end
      pending_r <= '0;
      clk_r     <= '0;
      tick_r    <= '0;
      wr_err_r  <= 1'b0;
    end else begin
      cnt_r     <= cnt_s;
      div_act_r <= div_act_s;
      shadow_r  <= shadow_s;
      pending_r <= pending_s;
      clk_r     <= clk_s;
      tick_r    <= tick_s;
      wr_err_r  <= wr_err_s;
    end
  end

  assign o_wr_err  = wr_err_r;
  assign o_pending = pending_r;
  assign o_clk     = clk_r;
  assign o_tick    = tick_r;

endmodule
